// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC and drives a 1-cycle synchronous instruction memory.
// Under decode stall it holds its outputs and keeps the returning word in a 1-entry skid.
module if_fetch_unit #(
  parameter logic [7:0]  PC_RESET  = 8'h00,
  parameter logic [7:0]  PC_STEP   = 8'd1,
  parameter logic [15:0] HALT_WORD = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_en,
  input  logic [7:0]  branch_addr,
  output logic        imem_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instruc_out,
  output logic [7:0]  addr_out,
  output logic        if_valid,
  output logic        halted
);

  logic [7:0]  pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [7:0]  req_addr_q, req_addr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_instr_q, skid_instr_d;
  logic [7:0]  skid_addr_q, skid_addr_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  addr_q, addr_d;
  logic        valid_q, valid_d;
  logic        halted_q, halted_d;

  logic        load_en_s;
  logic        load_valid_s;
  logic [15:0] load_instr_s;
  logic [7:0]  load_addr_s;
  logic        load_halt_s;
  logic        issue_s;
  logic [7:0]  issue_addr_s;

  // Pick the word that would enter the output registers: the skid has priority over memory.
  always_comb begin
    load_en_s    = !stall && !branch_en;
    load_valid_s = 1'b0;
    load_instr_s = imem_rdata;
    load_addr_s  = req_addr_q;
    if (skid_valid_q) begin
      load_valid_s = 1'b1;
      load_instr_s = skid_instr_q;
      load_addr_s  = skid_addr_q;
    end else if (req_valid_q) begin
      load_valid_s = 1'b1;
    end else begin
      load_valid_s = 1'b0;
    end
    load_halt_s = load_en_s && load_valid_s && (load_instr_s == HALT_WORD);
  end

  // Issue: a redirect always goes out; otherwise fetch only when flowing and not halting.
  always_comb begin
    issue_addr_s = branch_en ? branch_addr : pc_q;
    issue_s      = !rst && (branch_en || (!stall && !halted_q && !load_halt_s));
  end

  assign imem_en   = issue_s;
  assign imem_addr = issue_addr_s;

  // Next-state for PC, request tracking, skid and output registers.
  always_comb begin
    pc_d         = pc_q;
    req_valid_d  = issue_s;
    req_addr_d   = req_addr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_addr_d  = skid_addr_q;
    instr_d      = instr_q;
    addr_d       = addr_q;
    valid_d      = valid_q;
    halted_d     = halted_q;

    if (issue_s) begin
      pc_d       = issue_addr_s + PC_STEP;
      req_addr_d = issue_addr_s;
    end else begin
      req_addr_d = req_addr_q;
    end

    if (branch_en) begin
      // In-flight request and skid contents belong to the abandoned path.
      skid_valid_d = 1'b0;
      valid_d      = 1'b0;
      halted_d     = 1'b0;
    end else if (stall) begin
      if (req_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = imem_rdata;
        skid_addr_d  = req_addr_q;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end else begin
      skid_valid_d = 1'b0;
      if (load_valid_s) begin
        instr_d  = load_instr_s;
        addr_d   = load_addr_s;
        valid_d  = 1'b1;
        halted_d = halted_q || load_halt_s;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= PC_RESET;
      req_valid_q  <= 1'b0;
      req_addr_q   <= 8'h00;
      skid_valid_q <= 1'b0;
      skid_instr_q <= 16'h0000;
      skid_addr_q  <= 8'h00;
      instr_q      <= 16'h0000;
      addr_q       <= 8'h00;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_addr_q   <= req_addr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_addr_q  <= skid_addr_d;
      instr_q      <= instr_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
      halted_q     <= halted_d;
    end
  end

  assign instruc_out = instr_q;
  assign addr_out    = addr_q;
  assign if_valid    = valid_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios then random stall/branch/reset traffic,
// checked every cycle against a queue-based model of fetched-but-not-presented addresses.
module tb_if_fetch_unit;

  localparam logic [15:0] HALT = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst, stall, branch_en;
  logic [7:0]  branch_addr;
  logic        imem_en;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic [15:0] instruc_out;
  logic [7:0]  addr_out;
  logic        if_valid, halted;

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_en(branch_en), .branch_addr(branch_addr),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instruc_out(instruc_out), .addr_out(addr_out), .if_valid(if_valid), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: addresses issued but not yet presented, plus the presented word.
  logic [7:0]  m_pc;
  logic [7:0]  m_q[$];
  logic        m_valid, m_halted, m_zero;
  logic [7:0]  m_addr;
  logic [15:0] m_instr;

  task automatic model_reset();
    m_pc = 8'h00; m_q.delete(); m_valid = 1'b0; m_halted = 1'b0;
    m_zero = 1'b1; m_addr = 8'h00; m_instr = 16'h0000;
  endtask

  task automatic step(input logic r, input logic s, input logic b, input logic [7:0] ba);
    logic lh, exp_en;
    logic [7:0] a;
    @(negedge clk);
    check_eq("if_valid", {31'd0, if_valid}, {31'd0, m_valid});
    check_eq("halted", {31'd0, halted}, {31'd0, m_halted});
    if (m_valid || m_zero) begin
      check_eq("addr_out", {24'd0, addr_out}, {24'd0, m_addr});
      check_eq("instruc_out", {16'd0, instruc_out}, {16'd0, m_instr});
    end
    rst = r; stall = s; branch_en = b; branch_addr = ba;
    #1;
    lh = !r && !b && !s && (m_q.size() > 0) && (mem[m_q[0]] == HALT);
    exp_en = !r && (b || (!s && !m_halted && !lh));
    check_eq("imem_en", {31'd0, imem_en}, {31'd0, exp_en});
    if (exp_en) check_eq("imem_addr", {24'd0, imem_addr}, {24'd0, (b ? ba : m_pc)});
    if (r) begin
      model_reset();
    end else if (b) begin
      m_q.delete(); m_valid = 1'b0; m_halted = 1'b0;
      m_q.push_back(ba); m_pc = ba + 8'd1;
    end else if (!s) begin
      if (m_q.size() > 0) begin
        a = m_q.pop_front();
        m_valid = 1'b1; m_addr = a; m_instr = mem[a]; m_zero = 1'b0;
        if (m_instr == HALT) m_halted = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
      if (exp_en) begin
        m_q.push_back(m_pc); m_pc = m_pc + 8'd1;
      end
    end
  endtask

  task automatic run(input int n, input logic s);
    for (int i = 0; i < n; i++) step(1'b0, s, 1'b0, 8'h00);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    rst = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_addr = 8'h00;
    repeat (2) @(posedge clk);
    model_reset();

    // Linear fetch, then a 3-cycle stall around addr_out=5.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run(7, 1'b0);
    run(3, 1'b1);
    run(5, 1'b0);

    // Redirect to 0x40.
    step(1'b0, 1'b0, 1'b1, 8'h40);
    run(4, 1'b0);

    // Redirect while stalled.
    step(1'b0, 1'b1, 1'b1, 8'h20);
    run(2, 1'b1);
    run(4, 1'b0);

    // HALT word at address 3, then leave halt by branching to 0x10.
    mem[3] = HALT;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run(8, 1'b0);
    check_eq("halt_flag", {31'd0, halted}, 32'd1);
    step(1'b0, 1'b0, 1'b1, 8'h10);
    mem[3] = 16'h1003;
    run(4, 1'b0);
    check_eq("halt_left", {31'd0, halted}, 32'd0);

    // PC wrap, then reset while the skid holds a word.
    step(1'b0, 1'b0, 1'b1, 8'hFE);
    run(5, 1'b0);
    run(2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_eq("rst_valid", {31'd0, if_valid}, 32'd0);
    check_eq("rst_addr", {24'd0, addr_out}, 32'd0);
    run(4, 1'b0);

    // Random traffic over random memory with sparse HALT words.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 256; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? HALT : 16'($urandom_range(0, 16'hFFFE));
    step(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
           ($urandom_range(0, 99) < 8), 8'($urandom_range(0, 255)));
    end
    run(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage that produces the 16-bit instruction word and its 8-bit address consumed by the IF/ID pipeline buffer.
- Owns the PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Delivers one instruction per cycle with a valid flag, and holds under decode stall using a 1-entry skid register.
- Accepts branch redirects from later stages and stops fetching on a HALT word.

Parameters:
- PC_RESET, 8'h00, PC value loaded on reset.
- PC_STEP, 8'd1, PC increment per fetched word (word-addressed memory).
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- stall  in  1  IF/ID not accepting; hold outputs.
- branch_en  in  1  redirect request, one-cycle pulse.
- branch_addr  in  8  redirect target.
- imem_en  out  1  memory read strobe.
- imem_addr  out  8  memory read address.
- imem_rdata  in  16  read data, valid the cycle after imem_en.
- instruc_out  out  16  instruction presented to IF/ID.
- addr_out  out  8  address of instruc_out.
- if_valid  out  1  instruc_out/addr_out hold a real instruction.
- halted  out  1  fetch stopped by HALT_WORD.

Behaviour:
- State:
  - pc (next address to issue).
  - req_valid/req_addr (request issued last cycle).
  - skid_valid/skid_instr/skid_addr.
  - Output registers.
  - halted.
- Reset (rst=1 at edge): pc=PC_RESET, req_valid=0, skid_valid=0, instruc_out=0, addr_out=0, if_valid=0, halted=0. While rst=1, imem_en=0.
- Issue logic (combinational):
  - imem_addr = branch_en ? branch_addr : pc.
  - imem_en = branch_en OR (!stall AND !halted AND !load_halt).
  - load_halt = a HALT_WORD is being loaded into the output registers this cycle.
  - On issue: pc <= imem_addr + PC_STEP (8-bit wrap, 8'hFF+1 -> 8'h00, no flag); req_valid <= 1; req_addr <= imem_addr. Otherwise req_valid <= 0.
- Normal flow (stall=0, branch_en=0):
  - Output loads from skid if skid_valid (skid cleared); else from imem_rdata/req_addr if req_valid; else if_valid <= 0 (bubble).
  - Latency: address issued in cycle t appears at the outputs in cycle t+2.
  - Steady-state throughput: 1 instruction per cycle.
- Stall (stall=1, branch_en=0):
  - Output registers hold exactly.
  - No new issue.
  - If req_valid, the returning word is captured into skid.
  - Invariant: skid_valid and req_valid are never both 1. Skid depth 1 is sufficient; it must never overflow or drop a word.
- Branch (branch_en=1, overrides stall and halted):
  - branch_addr is issued this cycle.
  - The in-flight request is discarded and skid_valid <= 0.
  - if_valid <= 0 at the next edge.
  - halted <= 0.
  - Target appears at the outputs 2 cycles later if stall=0.
- Halt:
  - When the word being loaded into the output registers (from skid or memory) equals HALT_WORD, it is presented normally with if_valid=1 and halted <= 1 at that edge.
  - The same-cycle issue is suppressed.
  - Afterwards imem_en=0 and if_valid drops to 0 once the halt word is consumed (next non-stall cycle).
  - Only branch_en or rst leave halt.
  - A HALT_WORD arriving in the same cycle as branch_en is discarded; branch wins.
- Reset mid-stall or mid-branch: all state returns to reset values; skid contents are lost.

Test Plan:
- Memory word i = 16'h1000+i; release rst at cycle 0 -> imem_addr 0 at cycle 0; if_valid=1 with addr_out=0, instruc_out=16'h1000 at cycle 2; then addr_out 1,2,3 on consecutive cycles.
- Stall=1 for 3 cycles while addr_out=5 -> outputs hold 5 and imem_en=0 for all 3 cycles; after release addr_out=6 then 7; no loss or duplication; skid used once.
- branch_en=1, branch_addr=8'h40 at cycle t -> if_valid=0 at t+1; addr_out=8'h40 at t+2 and 8'h41 at t+3; the word in flight at t is never presented.
- branch_en and stall high together with branch_addr=8'h20 -> redirect taken; skid cleared; after stall release the first valid addr_out is 8'h20.
- HALT_WORD at address 3 -> addr_out=3 presented with if_valid=1; halted=1; imem_en=0 thereafter; later branch to 8'h10 -> halted=0 and addr_out=8'h10 two cycles later.
- Branch to 8'hFE, run 3 words -> addr_out 8'hFE, 8'hFF, 8'h00; assert rst during a stall with skid_valid=1 -> all outputs return to 0 and the skid is empty.
